// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-FU result FIFOs feeding one registered broadcast
// port, granted round-robin with a stall-able output register.
module cdb_arbiter #(
  parameter int XLEN          = 32,
  parameter int PHYS_REG_SIZE = 256,
  parameter int ROB_SIZE      = 256,
  parameter int NUM_FU        = 4,
  parameter int DEPTH         = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush,
  input  logic [NUM_FU-1:0]                     fu_valid,
  output logic [NUM_FU-1:0]                     fu_ready,
  input  logic [NUM_FU*$clog2(PHYS_REG_SIZE)-1:0] fu_reg,
  input  logic [NUM_FU*XLEN-1:0]                fu_val,
  input  logic [NUM_FU*$clog2(ROB_SIZE)-1:0]    fu_rob,
  output logic                                  update_valid,
  output logic [$clog2(PHYS_REG_SIZE)-1:0]      update_reg,
  output logic [XLEN-1:0]                       update_val,
  output logic [$clog2(ROB_SIZE)-1:0]           update_rob,
  output logic [$clog2(NUM_FU)-1:0]             update_grant,
  input  logic                                  update_ready
);

  localparam int PW = $clog2(PHYS_REG_SIZE);
  localparam int RW = $clog2(ROB_SIZE);
  localparam int GW = $clog2(NUM_FU);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = PW + XLEN + RW;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [GW:0]   NFU_C   = (GW + 1)'(NUM_FU);

  logic [EW-1:0] mem_q [NUM_FU][DEPTH];
  logic [AW-1:0] wptr_q [NUM_FU];
  logic [AW-1:0] wptr_d [NUM_FU];
  logic [AW-1:0] rptr_q [NUM_FU];
  logic [AW-1:0] rptr_d [NUM_FU];
  logic [CW-1:0] cnt_q  [NUM_FU];
  logic [CW-1:0] cnt_d  [NUM_FU];

  logic [GW-1:0]   rr_q, rr_d;
  logic            vld_q, vld_d;
  logic [PW-1:0]   reg_q, reg_d;
  logic [XLEN-1:0] val_q, val_d;
  logic [RW-1:0]   rob_q, rob_d;
  logic [GW-1:0]   gnt_q, gnt_d;

  logic [NUM_FU-1:0] push, pop, nonempty;
  logic              gnt_any;
  logic [GW-1:0]     gnt_idx;
  logic [GW:0]       rr_sum;
  logic              out_free;
  logic [EW-1:0]     head;

  // Ready is derived from registered occupancy only, so no input reaches it.
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      fu_ready[i] = (cnt_q[i] < DEPTH_C);
      nonempty[i] = (cnt_q[i] != '0);
      push[i]     = fu_valid[i] & (cnt_q[i] < DEPTH_C) & ~flush;
    end
  end

  // Rotating priority search starting at rr_q, wrapping past NUM_FU-1.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    rr_sum  = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      rr_sum = {1'b0, rr_q} + (GW + 1)'(k);
      if (rr_sum >= NFU_C) rr_sum = rr_sum - NFU_C;
      if (!gnt_any && nonempty[rr_sum[GW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = rr_sum[GW-1:0];
      end
    end
  end

  always_comb begin
    out_free = ~vld_q | update_ready;
    head     = mem_q[gnt_idx][rptr_q[gnt_idx]];
    for (int i = 0; i < NUM_FU; i++) begin
      pop[i] = out_free & ~flush & gnt_any & (gnt_idx == GW'(i));
    end

    vld_d = vld_q;
    reg_d = reg_q;
    val_d = val_q;
    rob_d = rob_q;
    gnt_d = gnt_q;
    rr_d  = rr_q;
    if (flush) begin
      vld_d = 1'b0;
    end else if (out_free) begin
      if (gnt_any) begin
        vld_d = 1'b1;
        reg_d = head[EW-1 -: PW];
        val_d = head[RW +: XLEN];
        rob_d = head[RW-1:0];
        gnt_d = gnt_idx;
        rr_d  = (gnt_idx == GW'(NUM_FU - 1)) ? '0 : gnt_idx + GW'(1);
      end else begin
        vld_d = 1'b0;
      end
    end

    for (int i = 0; i < NUM_FU; i++) begin
      wptr_d[i] = wptr_q[i];
      rptr_d[i] = rptr_q[i];
      cnt_d[i]  = cnt_q[i];
      if (flush) begin
        wptr_d[i] = '0;
        rptr_d[i] = '0;
        cnt_d[i]  = '0;
      end else begin
        if (push[i]) wptr_d[i] = wptr_q[i] + AW'(1);
        if (pop[i])  rptr_d[i] = rptr_q[i] + AW'(1);
        case ({push[i], pop[i]})
          2'b10:   cnt_d[i] = cnt_q[i] + CW'(1);
          2'b01:   cnt_d[i] = cnt_q[i] - CW'(1);
          default: cnt_d[i] = cnt_q[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_FU; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      rr_q  <= '0;
      vld_q <= 1'b0;
      reg_q <= '0;
      val_q <= '0;
      rob_q <= '0;
      gnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        wptr_q[i] <= wptr_d[i];
        rptr_q[i] <= rptr_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      rr_q  <= rr_d;
      vld_q <= vld_d;
      reg_q <= reg_d;
      val_q <= val_d;
      rob_q <= rob_d;
      gnt_q <= gnt_d;
    end
  end

  // Payload storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (push[i]) begin
        mem_q[i][wptr_q[i]] <= {fu_reg[i*PW +: PW], fu_val[i*XLEN +: XLEN], fu_rob[i*RW +: RW]};
      end
    end
  end

  assign update_valid = vld_q;
  assign update_reg   = reg_q;
  assign update_val   = val_q;
  assign update_rob   = rob_q;
  assign update_grant = gnt_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus random traffic, all checked
// against a queue-based model of the broadcast bus.
module tb_cdb_arbiter;
  localparam int N = 4;
  localparam int D = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [N-1:0]  fu_valid;
  logic [N-1:0]  fu_ready;
  logic [N*8-1:0]  fu_reg;
  logic [N*32-1:0] fu_val;
  logic [N*8-1:0]  fu_rob;
  logic          update_valid;
  logic [7:0]    update_reg;
  logic [31:0]   update_val;
  logic [7:0]    update_rob;
  logic [1:0]    update_grant;
  logic          update_ready;

  always #5 clk = ~clk;

  cdb_arbiter dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fu_valid(fu_valid), .fu_ready(fu_ready),
    .fu_reg(fu_reg), .fu_val(fu_val), .fu_rob(fu_rob),
    .update_valid(update_valid), .update_reg(update_reg), .update_val(update_val),
    .update_rob(update_rob), .update_grant(update_grant), .update_ready(update_ready)
  );

  typedef struct packed {
    logic [7:0]  r;
    logic [31:0] v;
    logic [7:0]  b;
  } ent_t;

  ent_t mq [N][$];
  int   m_rr;
  logic m_vld;
  ent_t m_out;
  int   m_gnt;
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) mq[i].delete();
    m_rr  = 0;
    m_vld = 1'b0;
    m_out = '0;
    m_gnt = 0;
  endtask

  task automatic check_all();
    check("valid", update_valid, m_vld);
    check("reg",   update_reg,   m_out.r);
    check("val",   update_val,   m_out.v);
    check("rob",   update_rob,   m_out.b);
    check("grant", update_grant, m_gnt);
    for (int i = 0; i < N; i++)
      check($sformatf("ready%0d", i), fu_ready[i], mq[i].size() < D);
  endtask

  task automatic set_fu(input int i, input logic [7:0] r, input logic [31:0] v, input logic [7:0] b);
    fu_reg[i*8 +: 8]  = r;
    fu_val[i*32 +: 32] = v;
    fu_rob[i*8 +: 8]  = b;
  endtask

  // Advance the model by one edge from the currently driven inputs, then check.
  task automatic step();
    bit   free;
    int   g;
    bit   acc [N];
    ent_t e;
    free = !m_vld || update_ready;
    if (flush) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      m_vld = 1'b0;
    end else begin
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && mq[(m_rr + k) % N].size() > 0) g = (m_rr + k) % N;
      for (int i = 0; i < N; i++) acc[i] = fu_valid[i] && (mq[i].size() < D);
      if (free) begin
        if (g >= 0) begin
          m_out = mq[g].pop_front();
          m_vld = 1'b1;
          m_gnt = g;
          m_rr  = (g + 1) % N;
        end else begin
          m_vld = 1'b0;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          e = {fu_reg[i*8 +: 8], fu_val[i*32 +: 32], fu_rob[i*8 +: 8]};
          mq[i].push_back(e);
        end
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Drop reset between edges; outputs must clear before the next edge.
  task automatic hw_reset();
    #2;
    rst = 1'b0;
    #1;
    check("rst_async_valid", update_valid, 1'b0);
    check("rst_async_ready", fu_ready, 4'hF);
    model_reset();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    flush = 1'b0;
    fu_valid = '0;
    fu_reg = '0;
    fu_val = '0;
    fu_rob = '0;
    update_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;

    // Single FU2 result
    update_ready = 1'b1;
    set_fu(2, 8'h15, 32'hDEADBEEF, 8'd7);
    fu_valid = 4'b0100;
    step();
    fu_valid = '0;
    step();
    check("t22_valid", update_valid, 1'b1);
    check("t22_reg",   update_reg,   8'h15);
    check("t22_val",   update_val,   32'hDEADBEEF);
    check("t22_rob",   update_rob,   8'd7);
    check("t22_grant", update_grant, 2'd2);
    check("t22_rr",    dut.rr_q,     2'd3);
    hw_reset();

    // All FUs at once from rr_ptr 0
    for (int i = 0; i < N; i++) set_fu(i, 8'h20 + 8'(i), 32'hA000 + i, 8'h40 + 8'(i));
    fu_valid = 4'hF;
    step();
    fu_valid = '0;
    for (int k = 0; k < N; k++) begin
      step();
      check("t23_valid", update_valid, 1'b1);
      check("t23_grant", update_grant, k);
    end
    step();
    check("t23_idle", update_valid, 1'b0);
    hw_reset();

    // FU1 back-to-back under backpressure
    update_ready = 1'b0;
    fu_valid = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      set_fu(1, 8'h30 + 8'(k), 32'hB000 + k, 8'h50 + 8'(k));
      step();
    end
    check("t24_full", fu_ready[1], 1'b0);
    fu_valid = '0;
    update_ready = 1'b1;
    repeat (4) step();

    // Frozen output while FU0/FU3 keep pushing
    set_fu(0, 8'h60, 32'hC000, 8'h61);
    fu_valid = 4'b0001;
    step();
    fu_valid = '0;
    step();
    update_ready = 1'b0;
    fu_valid = 4'b1001;
    for (int k = 0; k < 5; k++) begin
      set_fu(0, 8'h70 + 8'(k), 32'hC100 + k, 8'h71);
      set_fu(3, 8'h80 + 8'(k), 32'hC300 + k, 8'h81);
      step();
      check("t25_frozen", update_val, 32'hC000);
    end
    check("t25_ready", fu_ready, 4'b0110);
    fu_valid = '0;
    hw_reset();

    // Flush with three buffered entries and a colliding FU0 push
    update_ready = 1'b0;
    for (int i = 1; i < N; i++) set_fu(i, 8'h90 + 8'(i), 32'hE000 + i, 8'h91);
    fu_valid = 4'b1110;
    step();
    set_fu(0, 8'hBA, 32'h0BAD0BAD, 8'hBD);
    fu_valid = 4'b0001;
    flush = 1'b1;
    step();
    check("t26_valid", update_valid, 1'b0);
    check("t26_ready", fu_ready, 4'hF);
    flush = 1'b0;
    fu_valid = '0;
    update_ready = 1'b1;
    repeat (3) begin
      step();
      check("t26_nobcast", update_valid, 1'b0);
    end

    // Reset mid-stream with two entries still queued
    update_ready = 1'b0;
    for (int i = 0; i < 3; i++) set_fu(i, 8'hA0 + 8'(i), 32'hF000 + i, 8'hA1);
    fu_valid = 4'b0111;
    step();
    fu_valid = '0;
    step();
    check("t27_pre", update_valid, 1'b1);
    hw_reset();
    update_ready = 1'b1;
    repeat (3) begin
      step();
      check("t27_stale", update_valid, 1'b0);
    end

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      fu_valid = N'($urandom);
      for (int i = 0; i < N; i++) set_fu(i, 8'($urandom), $urandom, 8'($urandom));
      update_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 39) == 0);
      step();
      if ($urandom_range(0, 299) == 0) hw_reset();
    end
    flush = 1'b0;
    fu_valid = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
